// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH full-adder cells with a registered sum and carry-out.
// WIDTH=1 is the single-bit leaf cell used across the arithmetic datapaths.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;

  assign c[0] = Cin;

  // Plain ripple: carry into cell i+1 comes only from cell i.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      assign s[i]   = A[i] ^ B[i] ^ c[i];
      assign c[i+1] = (A[i] & B[i])
                    | (A[i] & c[i])
                    | (B[i] & c[i]);
    end
  endgenerate

  always_comb begin
    sum_d  = s;
    cout_d = c[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: 1-bit truth table, latency, async reset,
// and an 8-bit instance with carry-ripple corners and random vectors.
module tb_full_adder;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, cin1;
  logic       sum1, cout1;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] sum8;
  logic       cout8;

  int n_checks;
  int n_fail;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic s;
    logic co;
  } vec_t;

  vec_t vecs [8];

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (a1),
    .B    (b1),
    .Cin  (cin1),
    .Sum  (sum1),
    .Cout (cout1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (a8),
    .B    (b8),
    .Cin  (cin8),
    .Sum  (sum8),
    .Cout (cout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [8:0] act,
                       input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] exp8;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{a:1'b0, b:1'b0, cin:1'b0, s:1'b0, co:1'b0};
    vecs[1] = '{a:1'b0, b:1'b0, cin:1'b1, s:1'b1, co:1'b0};
    vecs[2] = '{a:1'b0, b:1'b1, cin:1'b0, s:1'b1, co:1'b0};
    vecs[3] = '{a:1'b0, b:1'b1, cin:1'b1, s:1'b0, co:1'b1};
    vecs[4] = '{a:1'b1, b:1'b0, cin:1'b0, s:1'b1, co:1'b0};
    vecs[5] = '{a:1'b1, b:1'b0, cin:1'b1, s:1'b0, co:1'b1};
    vecs[6] = '{a:1'b1, b:1'b1, cin:1'b0, s:1'b0, co:1'b1};
    vecs[7] = '{a:1'b1, b:1'b1, cin:1'b1, s:1'b1, co:1'b1};

    // Reset held with all-ones inputs: outputs must stay cleared.
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_hold_w1", {7'd0, cout1, sum1}, 9'h000);
      check("rst_hold_w8", {cout8, sum8}, 9'h000);
    end

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_release_w1", {7'd0, cout1, sum1}, 9'h003);
    check("rst_release_w8", {cout8, sum8}, 9'h1FF);

    // 1-bit exhaustive truth table, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      a1   = vecs[i].a;
      b1   = vecs[i].b;
      cin1 = vecs[i].cin;
      tick();
      check($sformatf("w1_vec%0d", i),
            {7'd0, cout1, sum1},
            {7'd0, vecs[i].co, vecs[i].s});
    end

    // Latency: inputs change after an edge, outputs hold until next edge.
    a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0;
    tick();
    check("lat_before", {7'd0, cout1, sum1}, 9'h001);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    #2;
    check("lat_hold", {7'd0, cout1, sum1}, 9'h001);
    tick();
    check("lat_after", {7'd0, cout1, sum1}, 9'h002);

    // Mid-operation reset between edges clears outputs without a clock.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
    tick();
    check("pre_midrst_w1", {7'd0, cout1, sum1}, 9'h003);
    check("pre_midrst_w8", {cout8, sum8}, 9'h047);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_w1", {7'd0, cout1, sum1}, 9'h000);
    check("midrst_w8", {cout8, sum8}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // 8-bit carry ripple corners.
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
    tick();
    check("w8_ff_00_1", {cout8, sum8}, 9'h100);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    tick();
    check("w8_7f_01_0", {cout8, sum8}, 9'h080);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    tick();
    check("w8_ff_ff_1", {cout8, sum8}, 9'h1FF);
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    tick();
    check("w8_00_00_0", {cout8, sum8}, 9'h000);

    // 8-bit random vectors against an arithmetic model.
    for (int r = 0; r < 1000; r++) begin
      a8   = 8'($urandom_range(0, 255));
      b8   = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      exp8 = 9'(a8) + 9'(b8) + 9'(cin8);
      tick();
      check("w8_rand", {cout8, sum8}, exp8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

Parameterizable ripple-carry full adder with registered outputs. It adds two operands and a carry-in, and presents the sum and carry-out one clock after the inputs are sampled. The default configuration (WIDTH = 1) is the single-bit full-adder cell used as the leaf of the team's arithmetic datapaths. Wider instances chain WIDTH single-bit cells internally and feed the pipeline register.

## Interface
Parameters:
- WIDTH, default 1: operand and sum width in bits; legal range is 1 to 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion takes effect immediately; release is sampled on a clk rising edge.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry-in into bit 0.
- Sum  output  WIDTH  registered sum, bits [WIDTH-1:0] of A+B+Cin.
- Cout  output  1  registered carry-out of bit WIDTH-1.

## Operation
- Bit cell i computes s[i] = A[i] ^ B[i] ^ c[i] and c[i+1] = (A[i]&B[i]) | (A[i]&c[i]) | (B[i]&c[i]), with c[0] = Cin.
- The combinational result {c[WIDTH], s} equals A + B + Cin, a WIDTH+1-bit unsigned value with no truncation.
- Cells are instantiated with a generate loop over the WIDTH bit positions as a pure ripple chain; no carry-lookahead.
- On each clk rising edge with rst_n high: Sum <= s and Cout <= c[WIDTH].
- While rst_n is low: Sum = 0 and Cout = 0, forced asynchronously and held until the first clk edge after release.
- There is no enable. A new result is captured on every clock edge.
- X or Z on any input propagates to the register. No masking is required.

## Timing
- Latency: exactly 1 clk cycle from input sample to output. Throughput: 1 result per cycle.
- Reset values: Sum = {WIDTH{1'b0}}, Cout = 1'b0.
- Reset asserted mid-stream: outputs clear within the same delta, independent of clk. The in-flight result is discarded.
- First valid output: the first clk rising edge after rst_n deasserts. It reflects the inputs present at that edge.
- Critical path: the WIDTH-cell carry ripple. It must close at the target clock for WIDTH ≤ 32.
- Inputs are assumed synchronous to clk. No input synchronizers.

## Test plan
- Reset: hold rst_n = 0 and toggle clk with A = B = Cin = 1 -> Sum = 0, Cout = 0 throughout. Release rst_n; next edge -> Sum = 1, Cout = 1.
- WIDTH = 1 exhaustive: apply all 8 combinations of {A, B, Cin}, one per cycle. For example, 0/1/0 -> Sum = 1, Cout = 0; 1/1/0 -> Sum = 0, Cout = 1; 1/1/1 -> Sum = 1, Cout = 1. Each result appears one cycle later.
- Latency check: change inputs just after an edge -> outputs stay unchanged until the next rising edge.
- Mid-operation reset: pull rst_n low between edges while Sum = 1 and Cout = 1 -> both go to 0 immediately, without waiting for clk.
- WIDTH = 8 carry ripple: A = 8'hFF, B = 8'h00, Cin = 1 -> Sum = 8'h00, Cout = 1. A = 8'h7F, B = 8'h01, Cin = 0 -> Sum = 8'h80, Cout = 0.
- WIDTH = 8 random: 1000 random vectors -> {Cout, Sum} == A + B + Cin, checked against a one-cycle-delayed model.
